// File: rtl/keccak_core_allocator.sv
// Round-robin lease allocator for the SHA3/Keccak cores behind the peripheral AXI slave.
// Optional lease watchdog enabled by defining KECCAK_ALLOC_TIMEOUT_EN.
module keccak_core_allocator #(
   parameter int NUM_REQ        = 4,
   parameter int NUM_CORES      = 4,
   parameter int CORE_IDX_W     = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_release,
   output logic [NUM_REQ-1:0]            grant_valid,
   output logic [NUM_REQ*CORE_IDX_W-1:0] grant_core,
   output logic [NUM_REQ-1:0]            lease_active,
   output logic [NUM_CORES-1:0]          core_reset,
   output logic [NUM_CORES-1:0]          core_busy,
   output logic [2:0]                    free_count,
   output logic                          err_release,
   output logic [NUM_REQ-1:0]            lease_revoked
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {REQ_IDLE, REQ_WAIT, REQ_HELD} req_state_e;

   req_state_e            state_q [NUM_REQ];
   req_state_e            state_d [NUM_REQ];
   logic [CORE_IDX_W-1:0] core_of [NUM_REQ];
   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      win_idx;
   logic [NUM_REQ-1:0]    eligible;
   logic [NUM_REQ-1:0]    expire;
   logic [NUM_REQ-1:0]    grant_d;
   logic [NUM_CORES-1:0]  busy_d;
   logic [NUM_CORES-1:0]  core_reset_d;
   logic [CORE_IDX_W-1:0] free_idx;
   logic [2:0]            busy_pop;
   logic                  win_found;
   logic                  core_found;
   logic                  do_grant;
   logic                  err_d;
   int                    arb_idx;

   if (NUM_CORES < 1 || NUM_CORES > 4 || NUM_CORES > (1 << CORE_IDX_W) || TIMEOUT_CYCLES < 2)
   begin : g_param_check
      $error("keccak_core_allocator: unsupported parameter set");
   end

   always_comb begin
      lease_active = '0;
      grant_core   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         lease_active[i] = (state_q[i] == REQ_HELD);
         grant_core[i*CORE_IDX_W +: CORE_IDX_W] = core_of[i];
      end
   end

   // Cores are only grantable once their busy bit is already clear, so a core
   // freed at this edge cannot be handed out again until the following one.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++)
         eligible[i] = req_valid[i] && (state_q[i] != REQ_HELD);
      core_found = 1'b0;
      free_idx   = '0;
      for (int c = NUM_CORES - 1; c >= 0; c--) begin
         if (!core_busy[c]) begin
            core_found = 1'b1;
            free_idx   = CORE_IDX_W'(c);
         end
      end
      win_found = 1'b0;
      win_idx   = '0;
      arb_idx   = 0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         arb_idx = (int'(rr_ptr) + j) % NUM_REQ;
         if (eligible[PTR_W'(arb_idx)]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(arb_idx);
         end
      end
      do_grant = win_found && core_found;
   end

   always_comb begin
      busy_d       = core_busy;
      core_reset_d = '0;
      grant_d      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         state_d[i] = state_q[i];
         grant_d[i] = do_grant && (win_idx == PTR_W'(i));
         case (state_q[i])
            REQ_IDLE, REQ_WAIT: begin
               if (do_grant && (win_idx == PTR_W'(i)))
                  state_d[i] = REQ_HELD;
               else if (req_valid[i])
                  state_d[i] = REQ_WAIT;
               else
                  state_d[i] = REQ_IDLE;
            end
            REQ_HELD: begin
               if (req_release[i] || expire[i]) begin
                  state_d[i]         = REQ_IDLE;
                  busy_d[core_of[i]] = 1'b0;
               end
            end
            default: state_d[i] = REQ_IDLE;
         endcase
         if (expire[i])
            core_reset_d[core_of[i]] = 1'b1;
      end
      if (do_grant) begin
         busy_d[free_idx]       = 1'b1;
         core_reset_d[free_idx] = 1'b1;
      end
      err_d = |(req_release & ~lease_active);
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            state_q[i] <= REQ_IDLE;
            core_of[i] <= '0;
         end
         rr_ptr        <= '0;
         core_busy     <= '0;
         grant_valid   <= '0;
         core_reset    <= '0;
         err_release   <= 1'b0;
         lease_revoked <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            state_q[i] <= state_d[i];
         core_busy     <= busy_d;
         grant_valid   <= grant_d;
         core_reset    <= core_reset_d;
         err_release   <= err_d;
         lease_revoked <= expire;
         if (do_grant) begin
            core_of[win_idx] <= free_idx;
            rr_ptr           <= PTR_W'((int'(win_idx) + 1) % NUM_REQ);
         end
      end
   end

`ifdef KECCAK_ALLOC_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] lease_cnt [NUM_CORES];

   // A release arriving in the expiry cycle takes precedence over the revoke.
   always_comb begin
      expire = '0;
      for (int i = 0; i < NUM_REQ; i++)
         expire[i] = (state_q[i] == REQ_HELD) && !req_release[i] &&
                     (lease_cnt[core_of[i]] == CNT_W'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         for (int c = 0; c < NUM_CORES; c++)
            lease_cnt[c] <= '0;
      end else begin
         for (int c = 0; c < NUM_CORES; c++) begin
            if (do_grant && (free_idx == CORE_IDX_W'(c)))
               lease_cnt[c] <= '0;
            else if (core_busy[c])
               lease_cnt[c] <= lease_cnt[c] + CNT_W'(1);
         end
      end
   end
`else
   assign expire = '0;
`endif

   always_comb begin
      busy_pop = '0;
      for (int c = 0; c < NUM_CORES; c++)
         busy_pop = busy_pop + {2'b00, core_busy[c]};
      free_count = 3'(NUM_CORES) - busy_pop;
   end

endmodule

// File: doc/keccak_core_allocator.md
Name: keccak_core_allocator

Overview:
- Shares the NUM_CORES SHA3/Keccak cores of the peripheral among NUM_REQ requesters, e.g. driver DMA channels or CPU contexts.
- Grants exclusive core leases round-robin and reports the granted core index; that index is the core-select address field [8:7] of the peripheral register map.
- Pulses a per-core reset at grant time, equivalent to writing COMMAND=1, so each lease starts from a clean sponge state.
- Sits beside the peripheral AXI slave in the same clock domain.

Parameters:
- NUM_REQ, 4: number of requesters.
- NUM_CORES, 4: number of Keccak cores; 1..4.
- CORE_IDX_W, 2: width of a core index.
- TIMEOUT_CYCLES, 4096: lease watchdog limit; used only with the optional feature.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  level; requester i wants a core.
- release  in  NUM_REQ  1-cycle pulse; requester i returns its core.
- grant_valid  out  NUM_REQ  1-cycle pulse; requester i has been granted a core.
- grant_core  out  NUM_REQ*CORE_IDX_W  per-requester held core index; valid while lease_active[i]=1.
- lease_active  out  NUM_REQ  requester i holds a core.
- core_reset  out  NUM_CORES  1-cycle pulse to core k on grant.
- core_busy  out  NUM_CORES  core k is leased.
- free_count  out  3  number of unleased cores.
- err_release  out  1  1-cycle pulse; release seen from a requester with no lease.
- lease_revoked  out  NUM_REQ  1-cycle pulse; watchdog revoked the lease (tied 0 without the feature).

Behaviour:
- Reset: synchronous when S_AXI_ARESETN=0 at a clock edge.
  - All outputs go to 0, except free_count=NUM_CORES.
  - All leases are cleared and the round-robin pointer is set to 0.
  - Reset mid-lease drops every lease silently; no core_reset pulse and no revoke pulse.
- Per-requester FSM: IDLE -> WAIT (req_valid=1, no lease) -> HELD (grant) -> IDLE (release, or revoke).
  - WAIT -> IDLE if req_valid drops before grant; the request is withdrawn with no side effect.
  - In HELD, req_valid is ignored; there is no second lease.
- Arbitration: at most one grant per cycle.
  - Pick the first WAIT requester at or after the pointer, wrapping modulo NUM_REQ.
  - Assign the lowest-index free core.
  - After a grant the pointer moves to winner+1, wrapping.
- Latency: req_valid first high at edge N with a core free gives grant_valid, core_reset, lease_active, core_busy and grant_core all registered at N+1.
- core_reset[k] asserts in the same cycle as the grant_valid that assigns core k.
- Release: release[i] in HELD frees the core at the next edge.
  - A core released at edge N is not grantable at edge N; it is grantable from edge N+1 onward.
- Release and grant to the same requester never coincide, since grant requires WAIT.
- release[i] while IDLE or WAIT: err_release pulses next cycle; state is unchanged.
- Full: with all cores leased, waiting requesters stay in WAIT with no grant_valid, and the pointer does not move.
- free_count = NUM_CORES - popcount(core_busy), updated the same cycle as core_busy.
- Invariant: no core index is held by two requesters; popcount(lease_active) = popcount(core_busy).

Optional Feature:
- KECCAK_ALLOC_TIMEOUT_EN defined:
  - Each core has a cycle counter, cleared on grant and incremented while leased.
  - Reaching TIMEOUT_CYCLES-1 revokes the lease: lease_revoked[i] pulses and the core and requester free at the next edge.
  - core_reset[k] pulses in that same cycle.
  - A release in the same cycle as expiry wins, with no revoke pulse.
- Undefined: no counters; leases last until release; lease_revoked is constant 0.

Test Plan:
- Single grant: after reset, req_valid=4'b0001 at edge 3 -> edge 4 shows grant_valid=0001, grant_core[0]=0, core_reset=0001, free_count=3.
- Round-robin: req_valid=4'b1111 held, no releases -> grants in order r0,r1,r2,r3 on consecutive cycles with cores 0,1,2,3; then free_count=0.
- Full/back-pressure: all 4 cores leased, r0 releases at edge N while r1 waits -> r1 granted core 0 at edge N+2, not N+1.
- Error path: release[2] pulsed while r2 is IDLE -> err_release=1 for one cycle; core_busy is unchanged.
- Reset mid-operation: 3 leases active, ARESETN=0 for one edge -> lease_active=0, core_busy=0, free_count=4, no core_reset pulse.
- Watchdog (KECCAK_ALLOC_TIMEOUT_EN, TIMEOUT_CYCLES=16): r0 holds core 0 with no release -> lease_revoked[0] and core_reset[0] pulse 16 cycles after the grant, and free_count returns to 4.
